// File: rtl/lut_layer_pkg.sv
// Shared types and elaboration helpers for the LUT layer evaluator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lut_layer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // cfg_sel encodings: which configuration store a write targets
    localparam logic CFG_SEL_LUT = 1'b0;
    localparam logic CFG_SEL_TBL = 1'b1;

    // Smallest r with 2**r >= v (0 for v <= 1)
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lut_layer_ram.sv
// LUT storage: single write port, single synchronous read port, no reset.
// Latency: read data valid one cycle after rd_en with rd_addr.
// Backpressure: none; both ports accept every cycle.
module lut_layer_ram #(
    parameter int DW = 4,
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [2**AW];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rd_en) rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/lut_layer_seq.sv
// Sequential LUT-network layer: one neuron per cycle via a shared LUT RAM.
// Latency: out_valid rises NEURONS+2 cycles after the input handshake.
// Backpressure: holds result in DONE until out_ready; in/cfg accepted only in IDLE.
module lut_layer_seq
    import lut_layer_pkg::*;
#(
    parameter int IN_W    = 128,
    parameter int BIT_W   = 4,
    parameter int FANIN   = 3,
    parameter int NEURONS = 5,
    localparam int GROUPS = IN_W / BIT_W,
    localparam int GIDX_W = clog2(GROUPS),
    localparam int LA_W   = FANIN * BIT_W,
    localparam int NI_W   = max2(1, clog2(NEURONS)),
    localparam int CFG_AW = NI_W + LA_W,
    localparam int CFG_DW = max2(BIT_W, GIDX_W)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NEURONS*BIT_W-1:0]   out_vec,
    input  logic                       cfg_we,
    input  logic                       cfg_sel,
    input  logic [CFG_AW-1:0]          cfg_addr,
    input  logic [CFG_DW-1:0]          cfg_wdata,
    output logic                       cfg_ready
);

    localparam int TBL_N = NEURONS * FANIN;
    localparam int TI_W  = max2(1, clog2(TBL_N));
    localparam logic [NI_W-1:0] K_LAST = NI_W'(NEURONS - 1);

    if (IN_W % BIT_W != 0) begin : g_bad_width
        $error("lut_layer_seq: IN_W must be a multiple of BIT_W");
    end
    if ((GROUPS & (GROUPS - 1)) != 0) begin : g_bad_groups
        $error("lut_layer_seq: IN_W/BIT_W must be a power of two");
    end

    state_t                          state_q;
    state_t                          state_d;
    logic [GROUPS-1:0][BIT_W-1:0]    in_q;
    logic [NEURONS-1:0][BIT_W-1:0]   out_q;
    logic [NI_W-1:0]                 k_q;
    logic                            issue_done_q;
    logic                            rd_vld_q;
    logic [NI_W-1:0]                 rd_k_q;
    logic                            wb_last_q;
    logic [GIDX_W-1:0]               conn_q [TBL_N];
    logic [LA_W-1:0]                 lut_addr;
    logic [BIT_W-1:0]                ram_rdat;
    logic                            accept;
    logic                            issue;
    logic                            cfg_ok;
    logic                            lut_we;
    logic                            tbl_we;
    logic                            unused_cfg;

    assign in_ready  = (state_q == ST_IDLE);
    assign cfg_ready = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_vec   = out_q;

    assign accept = in_valid && in_ready;
    assign issue  = (state_q == ST_EVAL) && !issue_done_q;

    // Config writes only land in IDLE; out-of-range neuron/table addresses drop
    assign cfg_ok = cfg_we && cfg_ready;
    assign lut_we = cfg_ok && (cfg_sel == CFG_SEL_LUT)
                    && (int'(cfg_addr[CFG_AW-1:LA_W]) < NEURONS);
    assign tbl_we = cfg_ok && (cfg_sel == CFG_SEL_TBL)
                    && (int'(cfg_addr) < TBL_N);

    // Upper wdata/addr bits are meaningful only for one of the two targets
    assign unused_cfg = ^{cfg_wdata, cfg_addr};

    // Connectivity table: no reset, survives rst_n
    always_ff @(posedge clk) begin
        if (tbl_we) conn_q[cfg_addr[TI_W-1:0]] <= cfg_wdata[GIDX_W-1:0];
    end

    // Gather the fan-in groups of neuron k; slot 0 lands in the MSBs
    always_comb begin
        lut_addr = '0;
        for (int s = 0; s < FANIN; s++) begin
            lut_addr[(FANIN-1-s)*BIT_W +: BIT_W] =
                in_q[conn_q[TI_W'(int'(k_q) * FANIN + s)]];
        end
    end

    lut_layer_ram #(
        .DW (BIT_W),
        .AW (CFG_AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (lut_we),
        .wr_addr (cfg_addr),
        .wr_dat  (cfg_wdata[BIT_W-1:0]),
        .rd_en   (issue),
        .rd_addr ({k_q, lut_addr}),
        .rd_dat  (ram_rdat)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: EVAL ends the cycle after the last write-back
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_EVAL;
            ST_EVAL: if (wb_last_q) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Capture, neuron issue counter, read pipeline and result write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q         <= '0;
            out_q        <= '0;
            k_q          <= '0;
            issue_done_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_k_q       <= '0;
            wb_last_q    <= 1'b0;
        end else begin
            rd_vld_q  <= issue;
            rd_k_q    <= k_q;
            wb_last_q <= rd_vld_q && (rd_k_q == K_LAST);
            if (accept) begin
                in_q         <= in_vec;
                k_q          <= '0;
                issue_done_q <= 1'b0;
            end else if (issue) begin
                k_q <= k_q + 1'b1;
                if (k_q == K_LAST) issue_done_q <= 1'b1;
            end
            if (rd_vld_q) out_q[rd_k_q] <= ram_rdat;
        end
    end

endmodule

// File: tb/tb_lut_layer_seq.sv
// Self-checking bench for lut_layer_seq at default parameters.
// Latency: checks result NEURONS+2 cycles after accept.
// Backpressure: exercises held out_ready, config gating and random handshakes.
module tb_lut_layer_seq;

    localparam int IN_W    = 128;
    localparam int NEURONS = 5;
    localparam int FANIN   = 3;
    localparam int OUT_W   = 20;
    localparam int CFG_AW  = 15;
    localparam int CFG_DW  = 5;
    localparam int LUT_N   = 4096;
    localparam int TBL_N   = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IN_W-1:0]   in_vec = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  out_vec;
    logic              cfg_we = 1'b0;
    logic              cfg_sel = 1'b0;
    logic [CFG_AW-1:0] cfg_addr = '0;
    logic [CFG_DW-1:0] cfg_wdata = '0;
    logic              cfg_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state: what the bench believes is stored
    logic [3:0] lut_m  [NEURONS][LUT_N];
    logic [4:0] conn_m [TBL_N];

    typedef struct {
        logic [IN_W-1:0]  in_v;
        logic [OUT_W-1:0] exp;
    } vec_t;
    vec_t tbl [6];

    logic [OUT_W-1:0] sbq [$];

    lut_layer_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [OUT_W-1:0] act,
                         input logic [OUT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] grp(input logic [IN_W-1:0] v, input int g);
        return v[g*4 +: 4];
    endfunction

    // Reference: gather the fan-in groups into a LUT index and look it up
    function automatic logic [OUT_W-1:0] model_eval(input logic [IN_W-1:0] v);
        logic [OUT_W-1:0] r;
        int a;
        r = '0;
        for (int k = 0; k < NEURONS; k++) begin
            a = 0;
            for (int s = 0; s < FANIN; s++)
                a = a * 16 + int'(grp(v, int'(conn_m[k*FANIN+s])));
            r[k*4 +: 4] = lut_m[k][a];
        end
        return r;
    endfunction

    // Closed form for the identity configuration: neuron k = group(3k+2) ^ k
    function automatic logic [OUT_W-1:0] ident_exp(input logic [IN_W-1:0] v);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int k = 0; k < NEURONS; k++)
            r[k*4 +: 4] = grp(v, 3*k + 2) ^ 4'(k);
        return r;
    endfunction

    task automatic cfg_write(input logic sel, input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = addr[CFG_AW-1:0];
        cfg_wdata = data[CFG_DW-1:0];
        tick();
    endtask

    task automatic lut_write(input int k, input int a, input int d);
        cfg_write(1'b0, k * LUT_N + a, d);
        lut_m[k][a] = d[3:0];
    endtask

    task automatic conn_write(input int i, input int g);
        cfg_write(1'b1, i, g);
        conn_m[i] = g[4:0];
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_one(input string name, input logic [IN_W-1:0] v,
                           input logic [OUT_W-1:0] exp);
        int lat;
        in_vec   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check({name, " latency"}, OUT_W'(lat), OUT_W'(7));
        check({name, " out_vec"}, out_vec, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [IN_W-1:0]  v;
        logic [OUT_W-1:0] snap;
        logic [OUT_W-1:0] e;
        int lat, sent, got, cyc;
        logic acc, hs;

        // Directed vector table for the identity configuration
        for (int g = 0; g < 32; g++) v[g*4 +: 4] = 4'(g % 16);
        tbl[0].in_v = v;
        tbl[1].in_v = '0;
        tbl[2].in_v = '1;
        for (int i = 3; i < 6; i++)
            tbl[i].in_v = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 6; i++) tbl[i].exp = ident_exp(tbl[i].in_v);

        // Reset state
        #2;
        check("rst out_vec",   out_vec, '0);
        check("rst out_valid", OUT_W'(out_valid), OUT_W'(0));
        check("rst in_ready",  OUT_W'(in_ready),  OUT_W'(1));
        check("rst cfg_ready", OUT_W'(cfg_ready), OUT_W'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Identity configuration
        for (int k = 0; k < NEURONS; k++)
            for (int a = 0; a < LUT_N; a++)
                lut_write(k, a, (a & 15) ^ k);
        for (int i = 0; i < TBL_N; i++) conn_write(i, i);
        cfg_we = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_one($sformatf("vec%0d", i), tbl[i].in_v, tbl[i].exp);

        // Out-of-range table address must not alias onto entry 2
        cfg_write(1'b1, 18, 31);
        cfg_we = 1'b0;
        run_one("tbl_oob", tbl[0].in_v, tbl[0].exp);

        // Backpressure: result held, no second accept until after handshake
        in_vec   = tbl[3].in_v;
        in_valid = 1'b1;
        tick();
        in_vec   = tbl[4].in_v;
        wait_out(lat);
        check("bp latency", OUT_W'(lat), OUT_W'(7));
        check("bp out_vec", out_vec, tbl[3].exp);
        snap = out_vec;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("bp hold vec c%0d", c), out_vec, snap);
            check($sformatf("bp hold vld c%0d", c), OUT_W'(out_valid), OUT_W'(1));
            check($sformatf("bp in_ready c%0d", c), OUT_W'(in_ready), OUT_W'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp bubble vld",  OUT_W'(out_valid), OUT_W'(0));
        check("bp bubble rdy",  OUT_W'(in_ready),  OUT_W'(1));
        check("bp retain vec",  out_vec, snap);
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check("bp2 latency", OUT_W'(lat), OUT_W'(7));
        check("bp2 out_vec", out_vec, tbl[4].exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while neuron 2 is being issued
        in_vec   = tbl[5].in_v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("mid rst out_vec",   out_vec, '0);
        check("mid rst out_valid", OUT_W'(out_valid), OUT_W'(0));
        check("mid rst in_ready",  OUT_W'(in_ready),  OUT_W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_one("post rst", tbl[0].in_v, tbl[0].exp);

        // Config writes during EVAL are dropped
        in_vec   = '0;
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        cfg_we    = 1'b1;
        cfg_sel   = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = 5'h0F;
        tick();
        tick();
        tick();
        cfg_we = 1'b0;
        wait_out(lat);
        check("gate eval out_vec", out_vec, ident_exp('0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_one("gate ignored", '0, ident_exp('0));

        // Config write together with accept in IDLE is seen by that evaluation
        lut_m[0][0] = 4'hF;
        in_vec    = '0;
        in_valid  = 1'b1;
        cfg_we    = 1'b1;
        cfg_sel   = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = 5'h0F;
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        wait_out(lat);
        check("gate idle latency", OUT_W'(lat), OUT_W'(7));
        check("gate idle out_vec", out_vec, model_eval('0));
        check("gate idle n0", OUT_W'(out_vec[3:0]), OUT_W'(4'hF));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Random configuration
        for (int i = 0; i < TBL_N; i++) conn_write(i, $urandom_range(0, 31));
        for (int k = 0; k < NEURONS; k++)
            for (int a = 0; a < LUT_N; a++)
                lut_write(k, a, $urandom_range(0, 15));
        cfg_we = 1'b0;
        tick();

        // Random traffic against the scoreboard
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 100 && cyc < 5000) begin
            if (!in_valid && sent < 100 && $urandom_range(0, 1) == 1) begin
                in_vec   = {$urandom, $urandom, $urandom, $urandom};
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rand extra: got result %h required none pending", out_vec);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("rand%0d", got), out_vec, e);
                end
                got++;
            end
            if (acc) begin
                sbq.push_back(model_eval(in_vec));
                sent++;
            end
            tick();
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand results", OUT_W'(got), OUT_W'(100));
        check("rand pending", OUT_W'(sbq.size()), OUT_W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lut_layer_seq.md
LUT_LAYER_SEQ -- requirements
Module: lut_layer_seq

Interface
REQ-001 SHALL have parameter IN_W, default 128, meaning input vector width in bits.
REQ-002 SHALL have parameter BIT_W, default 4, meaning bits per input group and per neuron output.
REQ-003 SHALL have parameter FANIN, default 3, meaning input groups per neuron.
REQ-004 SHALL have parameter NEURONS, default 5, meaning neurons per layer.
REQ-005 SHALL derive GROUPS=IN_W/BIT_W, GIDX_W=clog2(GROUPS), LA_W=FANIN*BIT_W, NI_W=max(1,clog2(NEURONS)), CFG_AW=NI_W+LA_W, CFG_DW=max(BIT_W,GIDX_W).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  in_vec is valid.
REQ-009 in_ready  output  1  block can accept in_vec.
REQ-010 in_vec  input  IN_W  activation vector; group g = in_vec[g*BIT_W +: BIT_W].
REQ-011 out_valid  output  1  out_vec holds a complete result.
REQ-012 out_ready  input  1  consumer accepts out_vec.
REQ-013 out_vec  output  NEURONS*BIT_W  neuron k result at [k*BIT_W +: BIT_W].
REQ-014 cfg_we  input  1  configuration write strobe.
REQ-015 cfg_sel  input  1  0 = LUT memory, 1 = connectivity table.
REQ-016 cfg_addr  input  CFG_AW  LUT: {neuron, lut_addr}; table: neuron*FANIN+slot in LSBs.
REQ-017 cfg_wdata  input  CFG_DW  LUT entry (BIT_W LSBs) or group index (GIDX_W LSBs).
REQ-018 cfg_ready  output  1  configuration writes are accepted this cycle.

Function
REQ-019 SHALL implement FSM IDLE, EVAL, DONE; in_ready=cfg_ready=(state==IDLE); out_valid=(state==DONE).
REQ-020 IDLE: on in_valid&&in_ready, register in_vec, clear neuron counter k, go to EVAL.
REQ-021 EVAL: each cycle issue neuron k: lut_addr = concatenation of groups conn[k][0..FANIN-1], slot 0 in MSBs; read LUT at {k, lut_addr}; k increments by 1.
REQ-022 LUT read SHALL be synchronous, 1 cycle; result for neuron k written to out_vec slice k the following cycle.
REQ-023 After issuing k=NEURONS-1, EVAL SHALL go to DONE once the last write-back completes; accept at edge 0 -> out_valid high after edge NEURONS+2 (7 at defaults).
REQ-024 DONE: out_vec and out_valid held stable while out_ready=0; on out_ready=1 go to IDLE (one-cycle bubble before next accept).
REQ-025 out_vec SHALL change only during EVAL write-backs; it retains the last result in IDLE.
REQ-026 cfg_we while cfg_ready=0 SHALL be ignored (no memory change); cfg_we with in_valid in IDLE: both take effect, the write visible to that evaluation.
REQ-027 Table addresses >= NEURONS*FANIN and LUT neuron fields >= NEURONS SHALL be ignored.
REQ-028 SHALL elaborate-time error if IN_W%BIT_W!=0 or GROUPS not a power of two.

Reset
REQ-029 rst_n low SHALL force state=IDLE, k=0, out_vec=0, out_valid=0, captured input=0 immediately, including mid-EVAL (evaluation aborted, no partial result reported).
REQ-030 LUT memory and connectivity table SHALL NOT be reset; contents undefined at power-up, preserved across reset.

Structure
REQ-031 Shared package lut_layer_pkg SHALL hold the FSM state enum, cfg_sel encodings, and clog2/max helper functions.
REQ-032 LUT storage SHALL be one sub-module lut_layer_ram (single write port, single synchronous read port, no reset), inferable as block RAM.

Verification
REQ-033 Identity: LUT[k][a]=a[BIT_W-1:0]^k, conn[k]={3k,3k+1,3k+2}, in_vec group g=g%16 -> out_vec neuron k = (3k+2)%16 ^ k, out_valid 7 cycles after accept.
REQ-034 Backpressure: hold out_ready=0 for 20 cycles -> out_vec stable, in_ready=0, second in_valid not accepted until 1 cycle after out_ready handshake.
REQ-035 Reset mid-EVAL: assert rst_n=0 at k=2 -> out_vec=0, out_valid=0 same cycle; next input yields correct full result.
REQ-036 Config gating: cfg_we during EVAL writes LUT[0][0]=0xF -> ignored; rewrite in IDLE -> next evaluation with all-zero input yields neuron 0 = 0xF.
REQ-037 Back-to-back: 100 random vectors with random in_valid/out_ready -> every result matches reference model, no vector dropped or duplicated.
